bdd_node_sram: RTL

Parametrised dual-port node-table memory for the BDD accelerator. It replaces the single-port sram.
- Separate synchronous write and read ports, usable in the same cycle.
- Registered read with a valid strobe.
- Per-entry valid bits, giving a "node present" hit flag.
- Occupancy count and bulk invalidate, so the traversal engine can reuse the table without clearing the data array.

---
 rtl/bdd_pkg.sv | 26 ++
 rtl/bdd_node_sram_if.sv | 28 ++
 rtl/bdd_valid_tracker.sv | 47 ++++
 rtl/bdd_node_sram.sv | 92 +++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared BDD accelerator definitions: node-word layout and default table geometry.
package bdd_pkg;

  localparam int unsigned VAR_W      = 8;
  localparam int unsigned PTR_W      = 12;
  localparam int unsigned NODE_W     = VAR_W + 2 * PTR_W;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DEPTH  = 32;

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    logic [PTR_W-1:0] lo;
    logic [PTR_W-1:0] hi;
  } bdd_node_t;

  function automatic bdd_node_t make_node(input logic [VAR_W-1:0] var_idx,
                                          input logic [PTR_W-1:0] lo,
                                          input logic [PTR_W-1:0] hi);
    bdd_node_t n;
    n.var_idx = var_idx;
    n.lo      = lo;
    n.hi      = hi;
    return n;
  endfunction

endpackage

// File: rtl/bdd_node_sram_if.sv
// Write/read/invalidate bus of the BDD node table; master drives requests, slave returns status.
interface bdd_node_sram_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 6
);
  logic                  i_wr_en;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_rd_en;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  i_inv;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  o_rd_hit;
  logic [CNT_W-1:0]      o_count;
  logic                  o_full;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr, i_inv,
    input  o_rd_data, o_rd_valid, o_rd_hit, o_count, o_full
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr, i_inv,
    output o_rd_data, o_rd_valid, o_rd_hit, o_count, o_full
  );
endinterface

// File: rtl/bdd_valid_tracker.sv
// Per-entry valid bits and occupancy count; invalidate clears before a same-cycle set.
module bdd_valid_tracker #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_set,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  input  logic                  i_inv,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_hit_c,
  output logic [CNT_W-1:0]      o_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid_d, valid_q;
  logic [CNT_W-1:0] count_d, count_q;

  // Count only moves on invalid-to-valid transitions, so it cannot exceed DEPTH.
  always_comb begin
    valid_d = i_inv ? '0 : valid_q;
    count_d = i_inv ? '0 : count_q;
    if (i_set) begin
      valid_d[IDX_W'(i_set_addr)] = 1'b1;
      if (i_inv || !valid_q[IDX_W'(i_set_addr)]) begin
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign o_hit_c = (32'(i_rd_addr) < DEPTH) && valid_q[IDX_W'(i_rd_addr)];
  assign o_count = count_q;

endmodule

// File: rtl/bdd_node_sram.sv
// Dual-port BDD node table: synchronous write, registered read with hit flag, bulk invalidate.
module bdd_node_sram
  import bdd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned DATA_WIDTH = NODE_W,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned BYPASS     = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bdd_node_sram_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH > 2 ** ADDR_WIDTH) begin : g_depth_check
    $error("bdd_node_sram: DEPTH exceeds address space");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_ok_c, rd_ok_c, same_c, trk_hit_c;
  logic [CNT_W-1:0]      count_c;
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_hit_d, rd_hit_q;
  logic                  rd_valid_d, rd_valid_q;

  assign wr_ok_c = bus.i_wr_en && (32'(bus.i_wr_addr) < DEPTH);
  assign rd_ok_c = 32'(bus.i_rd_addr) < DEPTH;
  assign same_c  = wr_ok_c && (bus.i_wr_addr == bus.i_rd_addr);

  bdd_valid_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) u_valid (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (wr_ok_c),
    .i_set_addr (bus.i_wr_addr),
    .i_inv      (bus.i_inv),
    .i_rd_addr  (bus.i_rd_addr),
    .o_hit_c    (trk_hit_c),
    .o_count    (count_c)
  );

  // Data array carries no reset so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok_c) begin
      mem_q[IDX_W'(bus.i_wr_addr)] <= bus.i_wr_data;
    end
  end

  // Hit uses pre-invalidate valid bits; forwarding overrides when enabled.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_hit_d   = rd_hit_q;
    rd_valid_d = bus.i_rd_en;
    if (bus.i_rd_en) begin
      if (!rd_ok_c) begin
        rd_data_d = '0;
        rd_hit_d  = 1'b0;
      end else if ((BYPASS != 0) && same_c) begin
        rd_data_d = bus.i_wr_data;
        rd_hit_d  = 1'b1;
      end else begin
        rd_data_d = mem_q[IDX_W'(bus.i_rd_addr)];
        rd_hit_d  = trk_hit_c;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data_q  <= '0;
      rd_hit_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_hit_q   <= rd_hit_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_hit   = rd_hit_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_count    = count_c;
  assign bus.o_full     = (count_c == CNT_W'(DEPTH));

endmodule
